// File: rtl/tick_uart_pkg.sv
// Shared state type and default frame geometry for the tick-driven UART transmitter.
// Latency: n/a (types only); backpressure: n/a.
package tick_uart_pkg;

  localparam int DEF_TICKS_PER_BIT = 4;
  localparam int DEF_DATA_BITS     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/tick_bit_timer.sv
// Counts enable strobes and flags the one that completes a bit period; clear restarts the period.
// Latency: bit_end is combinational with the final counted strobe; backpressure: none, free-running on enable.
module tick_bit_timer
  import tick_uart_pkg::*;
#(
  parameter int TICKS_PER_BIT = DEF_TICKS_PER_BIT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CW = $clog2(TICKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(TICKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // clear wins so a strobe landing on the restart edge is never counted
  assign bit_end = enable && !clear && (cnt == LAST_CNT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tick_uart_tx.sv
// Tick-paced UART transmitter: start bit, DATA_BITS LSB first, stop bit; o_done pulses as the stop bit ends.
// Latency: o_tx drops on the accepting edge; backpressure: o_ready low for the whole frame, i_valid ignored meanwhile.
module tick_uart_tx
  import tick_uart_pkg::*;
#(
  parameter int TICKS_PER_BIT = DEF_TICKS_PER_BIT,
  parameter int DATA_BITS     = DEF_DATA_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tick,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [IW-1:0]        bit_idx;
  logic                 accept;
  logic                 bit_end;

  assign o_ready = (state == ST_IDLE);
  assign o_busy  = !o_ready;
  assign accept  = i_valid && o_ready;

  tick_bit_timer #(
    .TICKS_PER_BIT(TICKS_PER_BIT)
  ) u_bit_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .clear  (accept),
    .enable (i_tick && o_busy),
    .bit_end(bit_end)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      o_tx    <= 1'b1;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            shreg   <= i_data;
            bit_idx <= '0;
            o_tx    <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            o_tx  <= shreg[0];
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            // shreg[1] is the bit that sits at the LSB after this shift
            shreg <= shreg >> 1;
            if (bit_idx == LAST_IDX) begin
              bit_idx <= '0;
              o_tx    <= 1'b1;
              state   <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              o_tx    <= shreg[1];
            end
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            o_done <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_uart_tx.sv
// Scoreboarded bench: a line monitor decodes frames using its own tick count and checks them against queued payloads.
// Latency/backpressure: inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_tick_uart_tx;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_tick = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       o_ready, o_tx, o_busy, o_done;

  tick_uart_tx #(.TICKS_PER_BIT(4), .DATA_BITS(8)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_tick (i_tick),
    .i_valid(i_valid),
    .i_data (i_data),
    .o_ready(o_ready),
    .o_tx   (o_tx),
    .o_busy (o_busy),
    .o_done (o_done)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  // tick source: one strobe per 6 clocks, gateable for stall tests
  bit tick_en = 1'b1;
  int phase = 0;
  always @(negedge i_clk) begin
    phase = (phase == 5) ? 0 : phase + 1;
    i_tick = tick_en && (phase == 5);
  end

  // line monitor state
  int   cyc = 0;
  int   frames_done = 0;
  int   last_done_cyc = 0;
  int   last_start_cyc = 0;
  bit   in_frame = 1'b0;
  int   mon_k = 0;
  int   mc = 0;
  logic cur_bit = 1'b1;
  logic [7:0] rx = 8'h00;
  logic [7:0] exp_b = 8'h00;

  initial begin : monitor
    logic t;
    forever begin
      @(posedge i_clk);
      t = i_tick;
      #1;
      cyc++;
      if (!i_rst_n) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        total++;
        if (o_done !== 1'b0) begin
          bad++;
          $display("FAIL idle_done: o_done=%b required 0 at cycle %0d", o_done, cyc);
        end
        if (o_tx === 1'b0) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_frame: start bit at cycle %0d with no payload queued", cyc);
            exp_b = 8'hxx;
          end else begin
            exp_b = exp_q.pop_front();
          end
          in_frame = 1'b1;
          mon_k = 0;
          mc = 0;
          cur_bit = 1'b0;
          rx = 8'h00;
          last_start_cyc = cyc;
        end
      end else begin
        if (t) mc++;
        if (mc == 4) begin
          mc = 0;
          mon_k++;
          if (mon_k == 10) begin
            total++;
            if (o_done !== 1'b1 || o_ready !== 1'b1 || o_tx !== 1'b1) begin
              bad++;
              $display("FAIL frame_end: done=%b ready=%b tx=%b required 1/1/1", o_done, o_ready, o_tx);
            end
            total++;
            if (rx !== exp_b) begin
              bad++;
              $display("FAIL frame_data: got %h required %h", rx, exp_b);
            end
            frames_done++;
            last_done_cyc = cyc;
            in_frame = 1'b0;
          end else begin
            cur_bit = o_tx;
            if (mon_k <= 8) begin
              rx[mon_k-1] = o_tx;
            end else begin
              total++;
              if (o_tx !== 1'b1) begin
                bad++;
                $display("FAIL stop_bit: tx=%b required 1", o_tx);
              end
            end
          end
        end else begin
          total++;
          if (o_tx !== cur_bit || o_done !== 1'b0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL bit_hold: k=%0d tx=%b req %b done=%b req 0 busy=%b req 1",
                     mon_k, o_tx, cur_bit, o_done, o_busy);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d);
    int n;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data = d;
    exp_q.push_back(d);
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (o_ready && n < 2000);
    i_valid = 1'b0;
    total++;
    if (o_ready) begin
      bad++;
      $display("FAIL accept_timeout: payload %h never accepted", d);
    end
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    total++;
    if (frames_done < target) begin
      bad++;
      $display("FAIL frame_timeout: frames=%0d required %0d", frames_done, target);
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    total++;
    if (o_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: tx=%b ready=%b busy=%b done=%b required 1/1/0/0",
               o_tx, o_ready, o_busy, o_done);
    end
    i_rst_n = 1'b1;
    repeat (4) @(negedge i_clk);
  endtask

  task automatic test_single_frame;
    int f0;
    f0 = frames_done;
    send_byte(8'hA5);
    wait_frames(f0 + 1);
    repeat (40) @(negedge i_clk);
    total++;
    if (frames_done !== f0 + 1 || o_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_frame: frames=%0d req %0d ready=%b req 1", frames_done - f0, 1, o_ready);
    end
  endtask

  task automatic test_back_to_back;
    int f0, d1, n;
    f0 = frames_done;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data = 8'h00;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    n = 0;
    while (o_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    i_data = 8'hFF;
    wait_frames(f0 + 1);
    d1 = last_done_cyc;
    n = 0;
    while (o_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    i_valid = 1'b0;
    total++;
    if (last_start_cyc - d1 != 1) begin
      bad++;
      $display("FAIL b2b_gap: second start %0d cycles after done, required 1", last_start_cyc - d1);
    end
    wait_frames(f0 + 2);
    repeat (10) @(negedge i_clk);
  endtask

  task automatic test_valid_while_busy;
    int f0;
    f0 = frames_done;
    send_byte(8'h96);
    repeat (20) @(negedge i_clk);
    i_valid = 1'b1;
    i_data = 8'h3C;
    repeat (100) @(negedge i_clk);
    i_valid = 1'b0;
    wait_frames(f0 + 1);
    repeat (60) @(negedge i_clk);
    total++;
    if (frames_done !== f0 + 1 || o_ready !== 1'b1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL busy_ignore: frames=%0d req 1 ready=%b req 1 queued=%0d req 0",
               frames_done - f0, o_ready, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    int f0, n;
    f0 = frames_done;
    send_byte(8'hE7);
    n = 0;
    while (!(mon_k == 4 && mc == 2) && n < 1000) begin
      @(negedge i_clk);
      n++;
    end
    i_rst_n = 1'b0;
    #1;
    total++;
    if (o_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort: tx=%b ready=%b busy=%b done=%b required 1/1/0/0",
               o_tx, o_ready, o_busy, o_done);
    end
    repeat (3) @(negedge i_clk);
    total++;
    if (frames_done !== f0) begin
      bad++;
      $display("FAIL reset_no_done: frames=%0d required %0d", frames_done, f0);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_valid = 1'b1;
    i_data = 8'h5A;
    exp_q.push_back(8'h5A);
    @(negedge i_clk);
    i_valid = 1'b0;
    total++;
    if (o_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_accept: ready=%b required 0 after first edge", o_ready);
    end
    wait_frames(f0 + 1);
    repeat (10) @(negedge i_clk);
  endtask

  task automatic test_tick_stall;
    int f0, n, stall_bad;
    logic prev;
    f0 = frames_done;
    send_byte(8'hC3);
    n = 0;
    while (mon_k != 3 && n < 1000) begin
      @(negedge i_clk);
      n++;
    end
    tick_en = 1'b0;
    @(negedge i_clk);
    #1;
    prev = o_tx;
    stall_bad = 0;
    repeat (100) begin
      @(negedge i_clk);
      if (o_tx !== prev || o_busy !== 1'b1 || o_done !== 1'b0) stall_bad++;
    end
    total++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL tick_stall: %0d cycles changed, required 0", stall_bad);
    end
    tick_en = 1'b1;
    wait_frames(f0 + 1);
    repeat (10) @(negedge i_clk);
  endtask

  task automatic test_tick_on_accept;
    int f0, n;
    f0 = frames_done;
    n = 0;
    do begin
      @(negedge i_clk);
      #1;
      n++;
    end while (i_tick !== 1'b1 && n < 20);
    i_valid = 1'b1;
    i_data = 8'h81;
    exp_q.push_back(8'h81);
    @(negedge i_clk);
    i_valid = 1'b0;
    total++;
    if (o_ready !== 1'b0) begin
      bad++;
      $display("FAIL tick_accept: ready=%b required 0", o_ready);
    end
    wait_frames(f0 + 1);
    repeat (10) @(negedge i_clk);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_valid_while_busy();
    test_reset_mid_frame();
    test_tick_stall();
    test_tick_on_accept();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_uart_tx.md
TICK_UART_TX -- requirements
Module: tick_uart_tx

Interface
REQ-001 Parameter: TICKS_PER_BIT, 4, number of i_tick strobes per serial bit period (legal range 2..16).
REQ-002 Parameter: DATA_BITS, 8, payload bits per frame (legal range 5..8).
REQ-003 Port: i_clk  input  1  system clock (6 MHz); all state changes on its rising edge.
REQ-004 Port: i_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: i_tick  input  1  one-cycle enable strobe from the upstream 6->1 MHz divider, nominally one pulse per 6 i_clk cycles.
REQ-006 Port: i_valid  input  1  i_data holds a byte to transmit.
REQ-007 Port: i_data  input  DATA_BITS  payload, sampled only on acceptance.
REQ-008 Port: o_ready  output  1  block is idle and can accept a payload.
REQ-009 Port: o_tx  output  1  serial line, idle high, registered.
REQ-010 Port: o_busy  output  1  a frame is in progress.
REQ-011 Port: o_done  output  1  one-cycle pulse when a frame's stop bit completes.

Function
REQ-012 Frame format: 8N1-style: one start bit (0), DATA_BITS data bits LSB first, one stop bit (1).
REQ-013 FSM states: IDLE, START, DATA, STOP; IDLE->START on acceptance; START->DATA, DATA->STOP (after last data bit), and STOP->IDLE each at the end of a bit period.
REQ-014 Acceptance: occurs on a rising edge where i_valid=1 and o_ready=1; i_data latches into the shift register on that edge.
REQ-015 o_ready: 1 only in IDLE; o_busy is the exact complement of o_ready.
REQ-016 i_valid while busy: ignored; the latched payload and the frame are unaffected.
REQ-017 Start timing: o_tx goes 0 on the edge that accepts the payload; the tick counter clears on that same edge.
REQ-018 Bit period: ends on the TICKS_PER_BIT-th i_tick counted after entry to the bit; the next bit's o_tx value appears on that same edge.
REQ-019 Tick coincident with acceptance: not counted.
REQ-020 Tick counting: i_tick is counted only outside IDLE; ticks in IDLE have no effect.
REQ-021 Counter width: the tick counter is $clog2(TICKS_PER_BIT) bits and wraps to 0 at each bit end; the bit index is $clog2(DATA_BITS) bits.
REQ-022 Shift direction: the data shift register shifts right by one at each data-bit end.
REQ-023 Stall: absence of i_tick holds o_tx and all state indefinitely; there is no timeout.
REQ-024 o_done: asserts on the edge leaving STOP, for exactly one cycle; o_ready rises on the same edge.
REQ-025 Back-to-back frames: the next frame may be accepted the cycle after o_done, giving a minimum of one idle cycle between frames.

Reset
REQ-026 Reset values: while i_rst_n=0, the FSM is IDLE, o_tx=1, o_ready=1, o_busy=0, o_done=0, and all counters and the shift register are 0.
REQ-027 Reset mid-frame: reset applied mid-frame abandons the frame immediately, with no stop bit and no o_done.
REQ-028 Reset release: after i_rst_n deasserts, the first acceptance is possible on the first following rising edge.

Structure
REQ-029 Shared package: the FSM state typedef (enum logic[1:0]) and the default TICKS_PER_BIT/DATA_BITS constants reside in the shared package tick_uart_pkg.
REQ-030 Sub-module: one sub-module, tick_bit_timer, owns the tick counter and emits a one-cycle bit_end strobe; it has clear and enable inputs.

Verification (TICKS_PER_BIT=4, DATA_BITS=8, i_tick every 6 clocks)
REQ-031 Single frame: accept 0xA5 -> o_tx = 0,1,0,1,0,0,1,0,1,1, each bit lasting 4 ticks (24 clocks) except the start bit; exactly one o_done pulse; then o_ready=1.
REQ-032 Back-to-back: hold i_valid with 0x00 then 0xFF -> two complete frames; second acceptance exactly 1 cycle after the first o_done; second frame's data bits all 1.
REQ-033 i_valid while busy: during a frame, drive i_valid=1 with 0x3C -> ignored; transmitted bits match the original payload; no extra frame follows without a fresh handshake in IDLE.
REQ-034 Reset mid-frame: assert i_rst_n=0 mid data bit 3 -> o_tx=1 and o_ready=1 before the next clock edge; no o_done; a subsequent 0x5A frame is transmitted correctly.
REQ-035 Tick stall: suppress i_tick for 100 cycles mid-frame -> o_tx constant and no state change; on resumption the frame completes with correct bit order.
REQ-036 Tick on acceptance: i_tick coincident with the acceptance edge -> not counted; the start bit ends on the 4th subsequent tick.
